mem_stage_lsu: RTL

Parametrised memory-stage load/store unit for the RV32/RV64 pipeline; it replaces the single-cycle memory stage. It sits between the execute/memory pipeline register and the writeback stage. It drives a variable-latency data-memory bus with a req/ack handshake, places store data onto byte lanes, and extracts and sign/zero-extends load data. It stalls upstream while a bus access is outstanding, flags misaligned accesses and bus timeouts, and registers all results into the writeback stage.

---
 rtl/mem_stage_lsu.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit for an RV32/RV64 pipeline.
//
// Sits between the M pipeline register and the writeback stage. Memory ops
// that are aligned and legal for XLEN are issued on a variable-latency
// req/ack bus while upstream is stalled. Everything else, including
// misaligned ops, goes straight to W in one cycle. All W outputs and all
// bus outputs are registered.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   ValidM .. LoadSrcM           instruction in M (control, address, store data)
//   StallM                       upstream must hold while an access is in flight
//   mem_req/we/addr/be/wdata     data bus request, held stable while mem_req=1
//   mem_ack, mem_rdata           bus completion and read data (valid with ack)
//   ValidW .. BusErrW            writeback register outputs
//   state_dbg                    FSM state (0 = IDLE, 1 = BUSY)
//
// Bus handshake: mem_req rises on the accept edge and is held, together with
// mem_we/addr/be/wdata, until the edge that samples mem_ack=1 or the edge at
// which the timeout expires. mem_ack is only looked at while mem_req is high;
// an ack in the very first request cycle is legal. If ack and timeout land on
// the same edge, the ack wins.
module mem_stage_lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic              MemReadM,
  input  logic [1:0]        ResultSrcM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  input  logic [4:0]        RdM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [1:0]        StoreSrcM,
  input  logic [2:0]        LoadSrcM,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              ValidW,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [4:0]        RdW,
  output logic [XLEN-1:0]   ALUResultW,
  output logic [XLEN-1:0]   ReadDataW,
  output logic [XLEN-1:0]   PCPlus4W,
  output logic              MisalignW,
  output logic              BusErrW,
  output logic              state_dbg
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TMO_EN = (TIMEOUT != 0);
  // The counter starts at 0 in the first request cycle, so the request has
  // been up for TIMEOUT cycles when it reads TIMEOUT-1 without an ack.
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   tmo_cnt;

  // Captured op while the bus access is outstanding.
  logic            we_q;
  logic [OW-1:0]   off_q;
  logic [2:0]      ld_type_q;
  logic            rw_q;
  logic [1:0]      rsrc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] pc_q;

  // Decode of the op currently in M.
  logic            mem_op;
  logic [1:0]      size;
  logic            size_legal;
  logic            align_bad;
  logic            misalign_m;
  logic [OW-1:0]   offset;
  logic [7:0]      smask;
  logic [NB-1:0]   be_m;
  logic [XLEN-1:0] wdata_m;
  logic [XLEN-1:0] addr_m;
  logic            tmo_hit;

  always_comb begin
    mem_op = ValidM & (MemReadM | MemWriteM);
    size   = MemWriteM ? StoreSrcM : LoadSrcM[1:0];
    // Dword-sized codes (sd, ld, lwu) only exist on RV64; 111 is unused.
    if (MemWriteM)
      size_legal = (StoreSrcM != 2'b11) || (XLEN == 64);
    else
      size_legal = (LoadSrcM != 3'b111) &&
                   (((LoadSrcM != 3'b011) && (LoadSrcM != 3'b110)) || (XLEN == 64));
    case (size)
      2'b00:   align_bad = 1'b0;
      2'b01:   align_bad = ALUResultM[0];
      2'b10:   align_bad = |ALUResultM[1:0];
      default: align_bad = |ALUResultM[2:0];
    endcase
    misalign_m = ~size_legal | align_bad;
    offset     = ALUResultM[OW-1:0];
    case (size)
      2'b00:   smask = 8'h01;
      2'b01:   smask = 8'h03;
      2'b10:   smask = 8'h0F;
      default: smask = 8'hFF;
    endcase
    be_m    = NB'(smask) << offset;
    wdata_m = WriteDataM << {offset, 3'b000};
    addr_m  = {ALUResultM[XLEN-1:OW], {OW{1'b0}}};
    tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);
  end

  // Load extraction from the lanes selected by the captured offset.
  logic [XLEN-1:0] shifted;
  logic [63:0]     sh64;
  logic [63:0]     ext64;
  logic [XLEN-1:0] load_data;

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    sh64    = 64'(shifted);
    case (ld_type_q)
      3'b000:  ext64 = {{56{sh64[7]}},  sh64[7:0]};
      3'b001:  ext64 = {{48{sh64[15]}}, sh64[15:0]};
      3'b010:  ext64 = {{32{sh64[31]}}, sh64[31:0]};
      3'b011:  ext64 = sh64;
      3'b100:  ext64 = {56'd0, sh64[7:0]};
      3'b101:  ext64 = {48'd0, sh64[15:0]};
      3'b110:  ext64 = {32'd0, sh64[31:0]};
      default: ext64 = 64'd0;
    endcase
    load_data = ext64[XLEN-1:0];
  end

  assign StallM    = (state == BUSY);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      off_q      <= '0;
      ld_type_q  <= '0;
      rw_q       <= 1'b0;
      rsrc_q     <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      pc_q       <= '0;
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      RdW        <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      MisalignW  <= 1'b0;
      BusErrW    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !misalign_m) begin
            state     <= BUSY;
            tmo_cnt   <= '0;
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= addr_m;
            mem_be    <= be_m;
            mem_wdata <= wdata_m;
            we_q      <= MemWriteM;
            off_q     <= offset;
            ld_type_q <= LoadSrcM;
            rw_q      <= RegWriteM;
            rsrc_q    <= ResultSrcM;
            rd_q      <= RdM;
            alu_q     <= ALUResultM;
            pc_q      <= PCPlus4M;
            // The accepted op is in flight; W sees a bubble meanwhile.
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
          end else begin
            // Pass-through path: non-memory op, bubble, or misaligned op.
            ValidW     <= ValidM;
            RegWriteW  <= ValidM & RegWriteM & ~(mem_op & misalign_m);
            MisalignW  <= mem_op & misalign_m;
            BusErrW    <= 1'b0;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= '0;
            PCPlus4W   <= PCPlus4M;
          end
        end
        BUSY: begin
          if (mem_ack || tmo_hit) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            ValidW     <= 1'b1;
            RegWriteW  <= mem_ack & rw_q;
            MisalignW  <= 1'b0;
            BusErrW    <= ~mem_ack;
            ResultSrcW <= rsrc_q;
            RdW        <= rd_q;
            ALUResultW <= alu_q;
            ReadDataW  <= (mem_ack && !we_q) ? load_data : '0;
            PCPlus4W   <= pc_q;
          end else begin
            tmo_cnt   <= tmo_cnt + 1'b1;
            ValidW    <= 1'b0;
            RegWriteW <= 1'b0;
            MisalignW <= 1'b0;
            BusErrW   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
